// File: rtl/comparison_sweeper.sv
// comparison_sweeper
//   Self-checking stimulus driver for a 4-bit comparison unit (eq / gt / le / max).
//   It drives every enabled (sel, b, a) vector onto the comparator input. After each
//   vector has settled, it samples the result and checks it against a golden model.
//   It accumulates the mismatch count and captures the first failing vector.
//
// Parameters
//   SETTLE   cycles each vector is held before cmp_in is sampled (>= 1)
//   OP_MASK  bit k set -> sweep op k (0 eq, 1 gt, 2 le, 3 max)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       1-cycle pulse, starts a sweep from IDLE or DONE
//   sw_out      comparator input {sel[1:0], b[3:0], a[3:0]}
//   cmp_in      comparator result (9 bits)
//   busy        high while sweeping
//   done        high after a sweep, held until the next start or rst
//   pass        valid with done, 1 iff no mismatches
//   err_count   number of mismatching vectors
//   fail_valid  a first mismatch has been captured
//   fail_vec    sw_out value of the first mismatch
//   fail_got    cmp_in value of the first mismatch
module comparison_sweeper #(
   parameter int unsigned SETTLE  = 2,
   parameter logic [3:0]  OP_MASK = 4'b1111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [9:0]  sw_out,
   input  logic [8:0]  cmp_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [10:0] err_count,
   output logic        fail_valid,
   output logic [9:0]  fail_vec,
   output logic [8:0]  fail_got
);

   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   settle_cnt;

   logic [1:0]         cur_sel;
   logic [3:0]         cur_a;
   logic [3:0]         cur_b;
   logic               first_ok;
   logic [1:0]         first_sel;
   logic               next_ok;
   logic [1:0]         next_sel;
   logic [8:0]         expected;
   logic               mismatch;
   logic               last_vec;
   logic [9:0]         next_vec;

   assign cur_sel = sw_out[9:8];
   assign cur_b   = sw_out[7:4];
   assign cur_a   = sw_out[3:0];

   // Lowest enabled op: the first op a sweep visits.
   always_comb begin
      first_ok  = 1'b0;
      first_sel = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (OP_MASK[k]) begin
            first_ok  = 1'b1;
            first_sel = 2'(k);
         end
      end
   end

   // Next enabled op above the current one, so masked ops are skipped.
   always_comb begin
      next_ok  = 1'b0;
      next_sel = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (OP_MASK[k] && (k > int'(cur_sel))) begin
            next_ok  = 1'b1;
            next_sel = 2'(k);
         end
      end
   end

   // Golden comparator model. Unlisted bits are zero.
   always_comb begin
      expected = 9'd0;
      case (cur_sel)
         2'd0:    expected[0]   = (cur_a == cur_b);
         2'd1:    expected[0]   = (cur_a >  cur_b);
         2'd2:    expected[0]   = (cur_a <= cur_b);
         default: expected[3:0] = (cur_a > cur_b) ? cur_a : cur_b;
      endcase
   end

   assign mismatch = (cmp_in != expected);

   // a increments fastest, then b. Wrapping {b,a} moves to the next enabled op.
   assign last_vec = (sw_out[7:0] == 8'hFF) && !next_ok;
   assign next_vec = (sw_out[7:0] == 8'hFF) ? {next_sel, 8'h00}
                                            : {cur_sel, sw_out[7:0] + 8'd1};

   // Sweep FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         settle_cnt <= '0;
         sw_out     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         fail_got   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  settle_cnt <= '0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  fail_got   <= '0;
                  if (first_ok) begin
                     sw_out <= {first_sel, 8'h00};
                     busy   <= 1'b1;
                     done   <= 1'b0;
                     pass   <= 1'b0;
                     state  <= S_DRIVE;
                  end else begin
                     // Nothing to sweep: report an immediate clean pass.
                     sw_out <= '0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     pass   <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end

            S_DRIVE: begin
               if (settle_cnt == CNT_W'(SETTLE - 1)) begin
                  settle_cnt <= '0;
                  state      <= S_CHECK;
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end

            S_CHECK: begin
               if (mismatch) begin
                  err_count <= err_count + 11'd1;
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= sw_out;
                     fail_got   <= cmp_in;
                  end
               end
               if (last_vec) begin
                  // sw_out keeps the last vector while DONE is held.
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !mismatch && (err_count == 11'd0);
                  state <= S_DONE;
               end else begin
                  sw_out <= next_vec;
                  state  <= S_DRIVE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comparison_sweeper.sv
// tb_comparison_sweeper
//   Bench for comparison_sweeper. It uses three instances: default parameters,
//   OP_MASK=4'b1000 and OP_MASK=4'b0000. Each instance is attached to a behavioural
//   comparator, and that comparator can be given a stuck-bit fault.
module tb_comparison_sweeper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Default instance
   logic        start0 = 1'b0;
   logic [9:0]  sw0;
   logic [8:0]  cmp0;
   logic        busy0, done0, pass0, fv0;
   logic [10:0] err0;
   logic [9:0]  fvec0;
   logic [8:0]  fgot0;
   int          fault0 = 0;

   // OP_MASK = 4'b1000 instance
   logic        start8 = 1'b0;
   logic [9:0]  sw8;
   logic [8:0]  cmp8;
   logic        busy8, done8, pass8, fv8;
   logic [10:0] err8;
   logic [9:0]  fvec8;
   logic [8:0]  fgot8;
   int          fault8 = 0;

   // OP_MASK = 4'b0000 instance
   logic        startz = 1'b0;
   logic [9:0]  swz;
   logic [8:0]  cmpz;
   logic        busyz, donez, passz, fvz;
   logic [10:0] errz;
   logic [9:0]  fvecz;
   logic [8:0]  fgotz;

   comparison_sweeper dut (
      .clk(clk), .rst(rst), .start(start0), .sw_out(sw0), .cmp_in(cmp0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .fail_valid(fv0), .fail_vec(fvec0), .fail_got(fgot0));

   comparison_sweeper #(.SETTLE(2), .OP_MASK(4'b1000)) dut_m8 (
      .clk(clk), .rst(rst), .start(start8), .sw_out(sw8), .cmp_in(cmp8),
      .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
      .fail_valid(fv8), .fail_vec(fvec8), .fail_got(fgot8));

   comparison_sweeper #(.SETTLE(2), .OP_MASK(4'b0000)) dut_m0 (
      .clk(clk), .rst(rst), .start(startz), .sw_out(swz), .cmp_in(cmpz),
      .busy(busyz), .done(donez), .pass(passz), .err_count(errz),
      .fail_valid(fvz), .fail_vec(fvecz), .fail_got(fgotz));

   // Comparator under test. Fault codes:
   // 1: eq bit0 stuck 0, 2: max bit3 stuck 0, 3: gt bit0 stuck 1, 4: bit8 stuck 1.
   function automatic logic [8:0] cmp_model(input logic [9:0] sw, input int fault);
      logic [3:0] a, b;
      logic [8:0] r;
      a = sw[3:0];
      b = sw[7:4];
      r = 9'd0;
      case (sw[9:8])
         2'd0:    r[0]   = (a == b);
         2'd1:    r[0]   = (a > b);
         2'd2:    r[0]   = (a <= b);
         default: r[3:0] = (a > b) ? a : b;
      endcase
      if (fault == 1 && sw[9:8] == 2'd0) r[0] = 1'b0;
      if (fault == 2 && sw[9:8] == 2'd3) r[3] = 1'b0;
      if (fault == 3 && sw[9:8] == 2'd1) r[0] = 1'b1;
      if (fault == 4)                    r[8] = 1'b1;
      return r;
   endfunction

   always_comb cmp0 = cmp_model(sw0, fault0);
   always_comb cmp8 = cmp_model(sw8, fault8);
   always_comb cmpz = cmp_model(swz, 0);

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Pulse start on the default instance, then count busy cycles until done.
   // If inject_at >= 0, pulse start again that many cycles into the sweep.
   task automatic run0(input int inject_at, output int cycles);
      bit timeout;
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      cycles  = 0;
      timeout = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         if (busy0) cycles++;
         if (done0) begin
            timeout = 1'b0;
            break;
         end
         start0 = (i == inject_at);
         @(negedge clk);
      end
      start0 = 1'b0;
      if (timeout) chk("run0_timeout", 32'd1, 32'd0);
   endtask

   typedef struct {
      int          fault;
      int          inject;
      logic [31:0] cycles;
      logic [31:0] err;
      logic [31:0] pass;
      logic [31:0] fv;
      logic [31:0] fvec;
      logic [31:0] fgot;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int cyc;
      bit to;

      tbl[0] = '{0, -1, 3072, 0,    1, 0, 32'h000, 32'h000};
      tbl[1] = '{1, -1, 3072, 16,   0, 1, 32'h000, 32'h000};
      tbl[2] = '{2, -1, 3072, 192,  0, 1, 32'h308, 32'h000};
      tbl[3] = '{3, -1, 3072, 136,  0, 1, 32'h100, 32'h001};
      tbl[4] = '{4, -1, 3072, 1024, 0, 1, 32'h000, 32'h101};
      tbl[5] = '{0, 500, 3072, 0,   1, 0, 32'h000, 32'h000};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_sw",   32'(sw0),   32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_pass", 32'(pass0), 32'd0);
      chk("rst_err",  32'(err0),  32'd0);
      chk("rst_fv",   32'(fv0),   32'd0);

      // Table-driven sweeps; each restart from DONE must clear the previous result
      for (int t = 0; t < 6; t++) begin
         fault0 = tbl[t].fault;
         run0(tbl[t].inject, cyc);
         chk($sformatf("t%0d_cycles", t), 32'(cyc),   tbl[t].cycles);
         chk($sformatf("t%0d_done", t),   32'(done0), 32'd1);
         chk($sformatf("t%0d_err", t),    32'(err0),  tbl[t].err);
         chk($sformatf("t%0d_pass", t),   32'(pass0), tbl[t].pass);
         chk($sformatf("t%0d_fv", t),     32'(fv0),   tbl[t].fv);
         chk($sformatf("t%0d_fvec", t),   32'(fvec0), tbl[t].fvec);
         chk($sformatf("t%0d_fgot", t),   32'(fgot0), tbl[t].fgot);
         chk($sformatf("t%0d_sw", t),     32'(sw0),   32'h3FF);
      end

      // A restart from DONE after a failing run clears the result and drops done
      fault0 = 1;
      run0(-1, cyc);
      chk("restart_pre_err", 32'(err0), 32'd16);
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      chk("restart_err",  32'(err0),  32'd0);
      chk("restart_fv",   32'(fv0),   32'd0);
      chk("restart_done", 32'(done0), 32'd0);
      chk("restart_busy", 32'(busy0), 32'd1);
      chk("restart_sw",   32'(sw0),   32'd0);

      // Reset at vector 100 mid-sweep, then reset and start together in IDLE
      repeat (300) @(negedge clk);
      chk("mid_err", 32'(err0), 32'd6);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_sw",   32'(sw0),   32'd0);
      chk("midrst_busy", 32'(busy0), 32'd0);
      chk("midrst_done", 32'(done0), 32'd0);
      chk("midrst_pass", 32'(pass0), 32'd0);
      chk("midrst_err",  32'(err0),  32'd0);
      chk("midrst_fv",   32'(fv0),   32'd0);
      chk("midrst_fvec", 32'(fvec0), 32'd0);
      chk("midrst_fgot", 32'(fgot0), 32'd0);
      start0 = 1'b1;
      @(negedge clk);
      chk("rst_start_busy", 32'(busy0), 32'd0);
      rst    = 1'b0;
      start0 = 1'b0;
      fault0 = 0;
      run0(-1, cyc);
      chk("post_rst_cycles", 32'(cyc),   32'd3072);
      chk("post_rst_pass",   32'(pass0), 32'd1);
      chk("post_rst_err",    32'(err0),  32'd0);

      // OP_MASK = 4'b1000 with max bit3 stuck at 0
      fault8 = 2;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      cyc = 0;
      to  = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (busy8) cyc++;
         if (done8) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      if (to) chk("m8_timeout", 32'd1, 32'd0);
      chk("m8_cycles", 32'(cyc),   32'd768);
      chk("m8_err",    32'(err8),  32'd192);
      chk("m8_pass",   32'(pass8), 32'd0);
      chk("m8_fv",     32'(fv8),   32'd1);
      chk("m8_fvec",   32'(fvec8), 32'h308);
      chk("m8_fgot",   32'(fgot8), 32'h000);

      // OP_MASK = 4'b0000: immediate clean done, never busy
      chk("m0_idle_busy", 32'(busyz), 32'd0);
      @(negedge clk) startz = 1'b1;
      @(negedge clk) startz = 1'b0;
      chk("m0_done", 32'(donez), 32'd1);
      chk("m0_pass", 32'(passz), 32'd1);
      chk("m0_busy", 32'(busyz), 32'd0);
      chk("m0_sw",   32'(swz),   32'd0);
      chk("m0_err",  32'(errz),  32'd0);
      @(negedge clk);
      chk("m0_hold_done", 32'(donez), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
